// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
//   opcode_e : 4-bit operation encoding (1110/1111 are illegal)
//   state_e  : control FSM states (IDLE accepts work, MUL runs the iterative multiplier)
//   flags_t  : registered condition flags
package alu_pkg;

    typedef enum logic [3:0] {
        OP_PASSA = 4'b0000,
        OP_PASSB = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0011,
        OP_AND   = 4'b0100,
        OP_OR    = 4'b0101,
        OP_XOR   = 4'b0110,
        OP_NOT   = 4'b0111,
        OP_SHL   = 4'b1000,
        OP_SHR   = 4'b1001,
        OP_ASR   = 4'b1010,
        OP_ADC   = 4'b1011,
        OP_MUL   = 4'b1100,
        OP_CMP   = 4'b1101
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic cf;
        logic of;
        logic sf;
        logic zf;
    } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle of the sequential ALU.
//   master : operand-fetch side (drives in_valid/OPCODE/A/B, observes ready, pulses and flags)
//   slave  : the ALU itself
// The tri-stated result bus (ALU_OUT/HI) stays on plain ports of the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       OPCODE;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             err;
    logic             CF;
    logic             OF;
    logic             SF;
    logic             ZF;

    modport master (
        output in_valid, OPCODE, A, B,
        input  in_ready, out_valid, err, CF, OF, SF, ZF
    );

    modport slave (
        input  in_valid, OPCODE, A, B,
        output in_ready, out_valid, err, CF, OF, SF, ZF
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per enabled edge.
//   clk, rst  : clock, synchronous active-high reset
//   en        : advance enable (state frozen when low)
//   start     : load operands a/b (taken only while en=1)
//   busy      : iteration in progress
//   done      : combinational, high on the enabled edge that completes the product
//   product   : combinational product value, valid while done=1
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               last_step;

    // The final partial product is folded in combinationally so the owner can
    // capture the full product on the very edge that finishes the iteration.
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign busy      = busy_q;
    assign done      = busy_q && en && last_step;
    assign product   = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (en) begin
            if (start) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, a};
                mplier_q <= b;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (last_step) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready input, registered result and
// CF/OF/SF/ZF flags, and an optional iterative multiplier.
//   clk, rst  : clock, synchronous active-high reset (highest priority)
//   en        : 1 = advance, 0 = freeze state (out_valid/err still self-clear)
//   oe        : 1 = drive ALU_OUT/HI, 0 = release them to 'z
//   bus       : handshake, opcode/operands, out_valid/err pulses and flags
//   ALU_OUT   : registered result (low half for MUL)
//   HI        : MUL high half, 0 after other result-writing ops
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             oe,
    alu_seq_if.slave         bus,
    output wire [WIDTH-1:0]  ALU_OUT,
    output wire [WIDTH-1:0]  HI
);
    localparam int MSB = WIDTH - 1;
    localparam int SW  = $clog2(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   res_q, hi_q, res_d;
    flags_t             flags_q, flags_d;
    logic               out_valid_q, err_q;

    opcode_e            op;
    logic               accept, illegal, is_mul, mul_start;
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum_add, sum_adc, sum_sub, shl_ext, shr_ext;
    logic [SW-1:0]      amt;
    logic [WIDTH-1:0]   a, b;

    assign a   = bus.A;
    assign b   = bus.B;
    assign op  = opcode_e'(bus.OPCODE);
    assign amt = b[SW-1:0];

    assign bus.in_ready  = en && (state_q == IDLE) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign is_mul        = (op == OP_MUL);
    assign illegal       = (bus.OPCODE[3:1] == 3'b111) || (is_mul && !MUL_EN);
    assign mul_start     = accept && is_mul && MUL_EN;

    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign bus.CF        = flags_q.cf;
    assign bus.OF        = flags_q.of;
    assign bus.SF        = flags_q.sf;
    assign bus.ZF        = flags_q.zf;

    assign ALU_OUT = oe ? res_q : 'z;
    assign HI      = oe ? hi_q  : 'z;

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .start   (mul_start),
                .a       (a),
                .b       (b),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    // All arithmetic is carried one bit wider so the carry falls out of bit WIDTH.
    // Subtraction as A + ~B + 1: carry-out is the inverted borrow.
    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_adc = sum_add + (WIDTH+1)'(flags_q.cf);
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    // Shift through a guard bit so the last bit shifted out lands in a fixed
    // position; a zero shift amount leaves the guard at 0.
    assign shl_ext = {1'b0, a} << amt;
    assign shr_ext = {a, 1'b0} >> amt;

    always_comb begin
        logic [WIDTH:0] asr_ext;
        asr_ext    = $signed({a, 1'b0}) >>> amt;
        res_d      = res_q;
        flags_d    = flags_q;
        flags_d.cf = 1'b0;
        flags_d.of = 1'b0;
        case (op)
            OP_PASSA: res_d = a;
            OP_PASSB: res_d = b;
            OP_AND:   res_d = a & b;
            OP_OR:    res_d = a | b;
            OP_XOR:   res_d = a ^ b;
            OP_NOT:   res_d = ~a;
            OP_ADD: begin
                res_d      = sum_add[MSB:0];
                flags_d.cf = sum_add[WIDTH];
                flags_d.of = (a[MSB] == b[MSB]) && (sum_add[MSB] != a[MSB]);
            end
            OP_ADC: begin
                res_d      = sum_adc[MSB:0];
                flags_d.cf = sum_adc[WIDTH];
                flags_d.of = (a[MSB] == b[MSB]) && (sum_adc[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                res_d      = sum_sub[MSB:0];
                flags_d.cf = !sum_sub[WIDTH];
                flags_d.of = (a[MSB] != b[MSB]) && (sum_sub[MSB] != a[MSB]);
            end
            OP_SHL: begin
                res_d      = shl_ext[MSB:0];
                flags_d.cf = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res_d      = shr_ext[WIDTH:1];
                flags_d.cf = shr_ext[0];
            end
            OP_ASR: begin
                res_d      = asr_ext[WIDTH:1];
                flags_d.cf = asr_ext[0];
            end
            default: res_d = res_q;
        endcase
        flags_d.sf = res_d[MSB];
        flags_d.zf = (res_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            res_q       <= '0;
            hi_q        <= '0;
            flags_q     <= '{cf: 1'b0, of: 1'b0, sf: 1'b0, zf: 1'b1};
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            if (en) begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            if (illegal) begin
                                err_q       <= 1'b1;
                                out_valid_q <= 1'b1;
                            end else if (is_mul) begin
                                state_q <= MUL;
                            end else begin
                                out_valid_q <= 1'b1;
                                flags_q     <= flags_d;
                                if (op != OP_CMP) begin
                                    res_q <= res_d;
                                    hi_q  <= '0;
                                end
                            end
                        end
                    end
                    MUL: begin
                        if (mul_done) begin
                            {hi_q, res_q} <= mul_product;
                            flags_q.cf    <= (mul_product[2*WIDTH-1:WIDTH] != '0);
                            flags_q.of    <= (mul_product[2*WIDTH-1:WIDTH] != '0);
                            flags_q.sf    <= mul_product[MSB];
                            flags_q.zf    <= (mul_product == '0);
                            out_valid_q   <= 1'b1;
                            state_q       <= IDLE;
                        end else if (!mul_busy) begin
                            // Multiplier idle without finishing: never strand the FSM.
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
